// File: rtl/pc_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pc_hazard_ctrl
// Program-counter and hazard controller for the MIPS fetch stage.
// Holds the fetch PC, advances it by PC_STEP each free cycle, applies branch
// (EX) and jump (ID) redirects, and inserts multi-cycle load-use stalls using
// a two-state FSM (RUN / STALL) with a down-counter.
//
// Ports
//   clk_i       in   1        clock, all state updates on the rising edge
//   rst         in   1        synchronous active-high reset
//   hold_i      in   1        external freeze (imem not ready)
//   haz_i       in   1        load-use hazard request, honoured in RUN only
//   haz_cyc_i   in   CNT_W+1  requested stall length in cycles
//   jmp_valid_i in   1        jump resolved in ID
//   jmp_addr_i  in   PC_W     jump target
//   br_valid_i  in   1        taken branch resolved in EX
//   br_addr_i   in   PC_W     branch target
//   pc_o        out  PC_W     current fetch PC (registered)
//   link_o      out  PC_W     pc_o+PC_STEP captured on a jump (registered)
//   stall_o     out  1        freeze IF/ID, bubble into ID/EX (combinational)
//   stall_cnt_o out  CNT_W    remaining STALL cycles (registered)
//   flush_if_o  out  1        kill instruction in IF (combinational)
//   flush_id_o  out  1        kill instruction in ID (combinational)
// ---------------------------------------------------------------------------
module pc_hazard_ctrl #(
    parameter int PC_W      = 16,
    parameter int PC_STEP   = 1,
    parameter int RST_PC    = 0,
    parameter int MAX_STALL = 3,
    parameter int CNT_W     = 2
) (
    input  logic             clk_i,
    input  logic             rst,
    input  logic             hold_i,
    input  logic             haz_i,
    input  logic [CNT_W:0]   haz_cyc_i,
    input  logic             jmp_valid_i,
    input  logic [PC_W-1:0]  jmp_addr_i,
    input  logic             br_valid_i,
    input  logic [PC_W-1:0]  br_addr_i,
    output logic [PC_W-1:0]  pc_o,
    output logic [PC_W-1:0]  link_o,
    output logic             stall_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic             flush_if_o,
    output logic             flush_id_o
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    localparam logic [PC_W-1:0]  STEP_C  = PC_W'(PC_STEP);
    localparam logic [PC_W-1:0]  RST_C   = PC_W'(RST_PC);
    localparam logic [CNT_W:0]   MAX_C   = (CNT_W+1)'(MAX_STALL);
    localparam logic [CNT_W:0]   ONE_C   = {{CNT_W{1'b0}}, 1'b1};

    state_t           state_r;
    logic [PC_W-1:0]  pc_r;
    logic [PC_W-1:0]  link_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W:0]   haz_len_s;
    logic             stall_s;
    logic             flush_if_s;
    logic             flush_id_s;

    // Clamp a requested stall length into [1, MAX_STALL]; zero means one cycle.
    function automatic logic [CNT_W:0] clamp_len(input logic [CNT_W:0] req);
        logic [CNT_W:0] len;
        if (req == {(CNT_W+1){1'b0}}) begin
            len = ONE_C;
        end else if (req > MAX_C) begin
            len = MAX_C;
        end else begin
            len = req;
        end
        return len;
    endfunction

    // Effective length of a newly accepted hazard.
    always_comb begin
        haz_len_s = clamp_len(haz_cyc_i);
    end

    // Stall and flush strobes; any redirect or hold suppresses the stall.
    always_comb begin
        stall_s    = 1'b0;
        flush_if_s = 1'b0;
        flush_id_s = 1'b0;
        if (rst) begin
            stall_s    = 1'b0;
            flush_if_s = 1'b0;
            flush_id_s = 1'b0;
        end else if (br_valid_i) begin
            flush_if_s = 1'b1;
            flush_id_s = 1'b1;
        end else if (jmp_valid_i) begin
            flush_if_s = 1'b1;
        end else if (hold_i) begin
            stall_s = 1'b0;
        end else begin
            case (state_r)
                ST_RUN:   stall_s = haz_i;
                ST_STALL: stall_s = 1'b1;
                default:  stall_s = 1'b0;
            endcase
        end
    end

    // PC, link register and stall FSM; priority rst > br > jmp > hold > haz > incr.
    always_ff @(posedge clk_i) begin
        if (rst) begin
            pc_r    <= RST_C;
            link_r  <= {PC_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            state_r <= ST_RUN;
        end else if (br_valid_i) begin
            pc_r    <= br_addr_i;
            cnt_r   <= {CNT_W{1'b0}};
            state_r <= ST_RUN;
        end else if (jmp_valid_i) begin
            pc_r    <= jmp_addr_i;
            link_r  <= pc_r + STEP_C;
            cnt_r   <= {CNT_W{1'b0}};
            state_r <= ST_RUN;
        end else if (hold_i) begin
            pc_r    <= pc_r;
            cnt_r   <= cnt_r;
            state_r <= state_r;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (haz_i) begin
                        // The accepting edge itself is the first held edge.
                        if (haz_len_s > ONE_C) begin
                            state_r <= ST_STALL;
                            cnt_r   <= CNT_W'(haz_len_s - ONE_C);
                        end else begin
                            state_r <= ST_RUN;
                            cnt_r   <= {CNT_W{1'b0}};
                        end
                    end else begin
                        pc_r <= pc_r + STEP_C;
                    end
                end
                ST_STALL: begin
                    if (cnt_r <= CNT_W'(1)) begin
                        state_r <= ST_RUN;
                        cnt_r   <= {CNT_W{1'b0}};
                    end else begin
                        cnt_r   <= cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_RUN;
                    cnt_r   <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign pc_o        = pc_r;
    assign link_o      = link_r;
    assign stall_cnt_o = cnt_r;
    assign stall_o     = stall_s;
    assign flush_if_o  = flush_if_s;
    assign flush_id_o  = flush_id_s;

endmodule
